// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, EX/MEM bundle layout and datapath source select for pipe_stage_reg
package pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam int PIPE_EM_W     = 128;
    localparam int EM_FIELD_W    = 32;
    localparam int EM_ALUOUT_LSB = 96;
    localparam int EM_WDATA_LSB  = 64;
    localparam int EM_PC_LSB     = 32;
    localparam int EM_INSTR_LSB  = 0;
    typedef enum logic [1:0] {SRC_HOLD, SRC_IN, SRC_SKID, SRC_BUBBLE} main_src_e;
endpackage

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: handshake FSM, in_ready/level and main/skid load selects; PIPE_SKID_EN adds the FULL state
module pipe_stage_ctrl import pipe_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] level,
`ifdef PIPE_SKID_EN
    output logic       skid_load,
`endif
    output main_src_e  main_src
);
    logic [1:0] state_q, state_d;
    logic       in_fire, out_fire;
    assign out_valid = state_q != ST_EMPTY;
    assign level     = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
`ifdef PIPE_SKID_EN
    logic in_ready_q;
    assign in_ready = in_ready_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != ST_FULL;
        end
    end
    always_comb begin
        state_d   = state_q;
        main_src  = SRC_HOLD;
        skid_load = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_src = SRC_BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) begin
                    state_d  = ST_HALF;
                    main_src = SRC_IN;
                end
                ST_HALF: if (in_fire && out_ready) begin
                    main_src = SRC_IN;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_fire) begin
                    main_src = SRC_BUBBLE;
                    state_d  = ST_EMPTY;
                end
                // in_ready is low here, so only the downstream side can move
                ST_FULL: if (out_fire) begin
                    main_src = SRC_SKID;
                    state_d  = ST_HALF;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d  = state_q;
        main_src = SRC_HOLD;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_src = SRC_BUBBLE;
        end else if (in_fire) begin
            state_d  = ST_HALF;
            main_src = SRC_IN;
        end else if (out_fire) begin
            state_d  = ST_EMPTY;
            main_src = SRC_BUBBLE;
        end
    end
`endif
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with stall, flush-to-bubble and level; PIPE_SKID_EN adds a 2-entry skid
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int                DATA_W     = PIPE_EM_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level
);
    main_src_e         main_src;
    logic [DATA_W-1:0] main_q, skid_q;
`ifdef PIPE_SKID_EN
    logic skid_load;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         skid_q <= BUBBLE_VAL;
        else if (flush)     skid_q <= BUBBLE_VAL;
        else if (skid_load) skid_q <= in_data;
    end
`else
    assign skid_q = BUBBLE_VAL;
`endif
    pipe_stage_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .level     (level),
`ifdef PIPE_SKID_EN
        .skid_load (skid_load),
`endif
        .main_src  (main_src)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   main_q <= BUBBLE_VAL;
        else if (main_src != SRC_HOLD) main_q <= main_src == SRC_IN   ? in_data :
                                                 main_src == SRC_SKID ? skid_q  : BUBBLE_VAL;
    end
    assign out_data = main_q;
endmodule
